aes128_decrypt_iter: RTL and testbench
======================================

// Module: aes128_decrypt_iter
// PURPOSE
//  Iterative AES-128 inverse cipher (FIPS-197 InvCipher), one round per clock. Counterpart of the
//  combinational AES_Encrypt path: UART-received ciphertext blocks are fed in and plaintext is returned.
//  Expands the round keys once into a register file, then decrypts blocks with valid/ready handshakes.
// PARAMETERS
//  KEY_DEFAULT  128'h000102030405060708090a0b0c0d0e0f  cipher key expanded after every reset
//  NR           10                                      round count; only 10 is legal (elab error otherwise)
// PORTS
//  clk        in   1    single clock, all state on rising edge
//  rst        in   1    synchronous, active-high reset
//  in_valid   in   1    cipher_in holds a block
//  in_ready   out  1    block accepted on in_valid&&in_ready edge
//  cipher_in  in   128  ciphertext, byte 0 in [127:120]
//  out_valid  out  1    plain_out valid
//  out_ready  in   1    consumer accepts on out_valid&&out_ready edge
//  plain_out  out  128  plaintext, same byte order as cipher_in
//  busy       out  1    state != IDLE
//  key_load   in   1    [AES_DEC_KEY_LOAD_EN only] request key expansion of key_in
//  key_in     in   128  [AES_DEC_KEY_LOAD_EN only] new cipher key
// BEHAVIOUR
//  Reset values: in_ready=0, out_valid=0, plain_out=0, busy=1, round counter=0, rk[0..10]=0; state=KEYEXP.
//  FSM: KEYEXP -> IDLE -> ROUND -> DONE -> IDLE.
//  KEYEXP: rk[0]=key; edge i (1..10) writes rk[i]=f(rk[i-1], Rcon[i]). After the 10th edge -> IDLE.
//    Takes 11 clocks from reset deassertion.
//  IDLE: in_ready=1. On accept: st <= cipher_in ^ rk[10], rnd <= 9, -> ROUND.
//  ROUND: each edge st <= InvMixCol(InvSub(InvShift(st)) ^ rk[rnd]) for rnd 9..1.
//    rnd==0 omits InvMixColumns. rnd==0 edge loads plain_out and sets out_valid -> DONE.
//  Latency: out_valid high exactly 10 clocks after the accept edge.
//  DONE: plain_out and out_valid held stable while out_ready=0. On out_valid&&out_ready -> IDLE.
//    out_valid=0 next cycle; in_ready=1 next cycle (no overlap; throughput 1 block per 12 clocks minimum).
//  in_valid while not IDLE: ignored, no acceptance; the source must hold the block.
//  rst mid-operation: block discarded, outputs return to reset values, key re-expanded from KEY_DEFAULT.
//  All byte ops are GF(2^8) mod x^8+x^4+x^3+x+1; rnd is a 4-bit counter, never wraps below 0.
// CONFIGURATION
//  AES_DEC_KEY_LOAD_EN defined:
//    adds key_load/key_in. In IDLE, key_load=1 -> KEYEXP with key_in (11 clocks).
//    key_load has priority: in_ready = IDLE && !key_load. key_load outside IDLE is ignored.
//  Undefined: ports absent; key fixed at KEY_DEFAULT.
// STRUCTURE
//  aes_pkg: SBOX/INV_SBOX tables, RCON[1..10], functions xtime, gmul, inv_mix_col, sub_word, rot_word.
//  Sub-module aes_inv_round: combinational InvShiftRows/InvSubBytes/AddRoundKey/optional InvMixColumns
//    (input last_round). Top holds FSM, counter, rk register file, handshake regs.
// TESTING
//  1. Reset, wait for in_ready, send cipher 69c4e0d86a7b0430d8cdb78070b4c55a
//     -> plain 00112233445566778899aabbccddeeff, out_valid exactly 10 clocks after accept.
//  2. Same block with out_ready=0 for 5 cycles -> plain_out/out_valid stable.
//     Single pop; in_ready returns cycle after pop.
//  3. Two blocks with in_valid held continuously -> both correct, in order;
//     no second accept before first pop.
//  4. Assert rst at round 5, then resend block from test 1
//     -> outputs zeroed during reset, in_ready after 11 clocks, correct result.
//  5. in_valid pulsed during KEYEXP and ROUND -> no acceptance, no out_valid.
//  6. [AES_DEC_KEY_LOAD_EN] key_load with 2b7e151628aed2a6abf7158809cf4f3c in IDLE while in_valid=1
//     -> in_ready=0 that cycle. Then cipher 3925841d02dc09fbdc118597196a0b32
//     -> plain 3243f6a8885a308d313198a2e0370734.

Source files
------------

// File: rtl/aes128_decrypt_iter_pkg.sv
// Shared types, AES byte tables and GF(2^8) helpers for the iterative AES-128 inverse cipher.
// Optional key-load feature of the block is controlled by AES_DEC_KEY_LOAD_EN.
package aes128_decrypt_iter_pkg;

  localparam int unsigned BLK_W = 128;
  localparam int unsigned RND_W = 4;

  typedef logic [BLK_W-1:0] block_t;

  typedef enum logic [1:0] {
    ST_KEYEXP,
    ST_IDLE,
    ST_ROUND,
    ST_DONE
  } state_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Entry 0 is unused; key expansion only reads RCON[1..10].
  localparam logic [0:10][7:0] RCON = {
    8'h8d, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
            gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
            gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
            gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // One AES-128 key schedule step: next round key from the previous one.
  function automatic block_t key_step(input block_t k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word(rot_word(k[31:0])) ^ {rc, 24'h000000};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

endpackage

// File: rtl/aes128_decrypt_iter_if.sv
// Block-in / block-out handshake bundle of the AES-128 decryptor.
// key_load/key_in exist only when AES_DEC_KEY_LOAD_EN is defined.
interface aes128_decrypt_iter_if;
  import aes128_decrypt_iter_pkg::*;

  logic   in_valid;
  logic   in_ready;
  block_t cipher_in;
  logic   out_valid;
  logic   out_ready;
  block_t plain_out;
  logic   busy;
`ifdef AES_DEC_KEY_LOAD_EN
  logic   key_load;
  block_t key_in;

  modport master (
    output in_valid, cipher_in, out_ready, key_load, key_in,
    input  in_ready, out_valid, plain_out, busy
  );
  modport slave (
    input  in_valid, cipher_in, out_ready, key_load, key_in,
    output in_ready, out_valid, plain_out, busy
  );
`else
  modport master (
    output in_valid, cipher_in, out_ready,
    input  in_ready, out_valid, plain_out, busy
  );
  modport slave (
    input  in_valid, cipher_in, out_ready,
    output in_ready, out_valid, plain_out, busy
  );
`endif
endinterface

// File: rtl/aes128_decrypt_iter_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey and,
// unless last_round, InvMixColumns.
module aes128_decrypt_iter_inv_round
  import aes128_decrypt_iter_pkg::*;
(
  input  block_t state_in,
  input  block_t round_key,
  input  logic   last_round,
  output block_t state_out_c
);

  block_t shifted;
  block_t added;

  // Byte (r, c) lives at index r + 4c, byte 0 in the top bits.
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127 - 8*(r + 4*c) -: 8] =
          INV_SBOX[state_in[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8]];
      end
    end
    added = shifted ^ round_key;
    state_out_c = added;
    if (!last_round) begin
      for (int c = 0; c < 4; c++) begin
        state_out_c[127 - 32*c -: 32] = inv_mix_col(added[127 - 32*c -: 32]);
      end
    end
  end

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 inverse cipher, one round per clock, with on-chip key expansion.
// Define AES_DEC_KEY_LOAD_EN to allow reloading the key through key_load/key_in.
module aes128_decrypt_iter
  import aes128_decrypt_iter_pkg::*;
#(
  parameter block_t      KEY_DEFAULT = 128'h000102030405060708090a0b0c0d0e0f,
  parameter int unsigned NR          = 10
) (
  input logic               clk,
  input logic               rst,
  aes128_decrypt_iter_if.slave bus
);

  if (NR != 10) begin : g_bad_nr
    $error("aes128_decrypt_iter: NR must be 10");
  end

  localparam logic [RND_W-1:0] RND_LAST  = RND_W'(NR);
  localparam logic [RND_W-1:0] RND_FIRST = RND_W'(NR - 1);

  state_e           state_q, state_d;
  logic [RND_W-1:0] rnd_q;
  block_t           st_q;
  block_t           plain_q;
  block_t           rk_q [0:10];
  block_t           cur_key;
  block_t           rk_new_c;
  block_t           round_out_c;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             key_load_c;
  logic             accept_c;

`ifdef AES_DEC_KEY_LOAD_EN
  block_t key_q;
  assign cur_key      = key_q;
  assign key_load_c   = (state_q == ST_IDLE) && bus.key_load;
  assign bus.in_ready = in_ready_q && !bus.key_load;
`else
  assign cur_key      = KEY_DEFAULT;
  assign key_load_c   = 1'b0;
  assign bus.in_ready = in_ready_q;
`endif

  assign accept_c      = (state_q == ST_IDLE) && bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.plain_out = plain_q;
  assign bus.busy      = busy_q;

  // Round key written on this KEYEXP edge: raw key first, then one schedule step per edge.
  assign rk_new_c = (rnd_q == '0) ? cur_key
                                  : key_step(rk_q[rnd_q - RND_W'(1)], RCON[rnd_q]);

  aes128_decrypt_iter_inv_round u_round (
    .state_in    (st_q),
    .round_key   (rk_q[rnd_q]),
    .last_round  (rnd_q == '0),
    .state_out_c (round_out_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_KEYEXP;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_KEYEXP: if (rnd_q == RND_LAST) state_d = ST_IDLE;
      ST_IDLE: begin
        if (key_load_c)    state_d = ST_KEYEXP;
        else if (accept_c) state_d = ST_ROUND;
      end
      ST_ROUND:  if (rnd_q == '0) state_d = ST_DONE;
      ST_DONE:   if (bus.out_ready) state_d = ST_IDLE;
      default:   state_d = ST_KEYEXP;
    endcase
  end

  // Handshake flags are registered copies of the state being entered.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b1;
    unique case (state_d)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
      ST_DONE: out_valid_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Datapath: round key file, working state, round counter, result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rnd_q   <= '0;
      st_q    <= '0;
      plain_q <= '0;
      rk_q    <= '{default: '0};
`ifdef AES_DEC_KEY_LOAD_EN
      key_q   <= KEY_DEFAULT;
`endif
    end else begin
      unique case (state_q)
        ST_KEYEXP: begin
          rk_q[rnd_q] <= rk_new_c;
          if (rnd_q != RND_LAST) rnd_q <= rnd_q + RND_W'(1);
        end
        ST_IDLE: begin
          if (key_load_c) begin
            rnd_q <= '0;
`ifdef AES_DEC_KEY_LOAD_EN
            key_q <= bus.key_in;
`endif
          end else if (accept_c) begin
            st_q  <= bus.cipher_in ^ rk_q[RND_LAST];
            rnd_q <= RND_FIRST;
          end
        end
        ST_ROUND: begin
          st_q <= round_out_c;
          if (rnd_q == '0) plain_q <= round_out_c;
          else             rnd_q   <= rnd_q - RND_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Directed bench for aes128_decrypt_iter using the FIPS-197 known-answer blocks.
// The key-reload step is built only with AES_DEC_KEY_LOAD_EN defined.
module tb_aes128_decrypt_iter;

  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  aes128_decrypt_iter_if bus ();

  aes128_decrypt_iter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Negedges until in_ready is seen (bounded).
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 40);
  endtask

  // Negedges until out_valid is seen (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 40);
  endtask

  initial begin
    int n;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.cipher_in = '0;
    bus.out_ready = 1'b0;
`ifdef AES_DEC_KEY_LOAD_EN
    bus.key_load  = 1'b0;
    bus.key_in    = '0;
`endif
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 128'(bus.in_ready), 128'(0));
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_plain_out", bus.plain_out, 128'(0));
    check("rst_busy", 128'(bus.busy), 128'(1));

    // 1: key expansion time, then the FIPS-197 C.1 block
    rst = 1'b0;
    wait_ready(n);
    check("t1_keyexp_clocks", 128'(n), 128'(11));
    check("t1_idle_busy", 128'(bus.busy), 128'(0));
    bus.in_valid  = 1'b1;
    bus.cipher_in = CT1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("t1_in_ready_after_accept", 128'(bus.in_ready), 128'(0));
    check("t1_busy_round", 128'(bus.busy), 128'(1));
    wait_valid(n);
    check("t1_latency", 128'(n), 128'(10));
    check("t1_plain", bus.plain_out, PT1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("t1_pop_out_valid", 128'(bus.out_valid), 128'(0));
    check("t1_pop_in_ready", 128'(bus.in_ready), 128'(1));

    // 2: back-pressure holds the result stable, one pop only
    bus.in_valid  = 1'b1;
    bus.cipher_in = CT1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_valid(n);
    check("t2_latency", 128'(n), 128'(10));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_hold_valid", 128'(bus.out_valid), 128'(1));
      check("t2_hold_plain", bus.plain_out, PT1);
      check("t2_hold_in_ready", 128'(bus.in_ready), 128'(0));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("t2_pop_in_ready", 128'(bus.in_ready), 128'(1));
    check("t2_pop_out_valid", 128'(bus.out_valid), 128'(0));
    @(negedge clk);
    check("t2_single_pop", 128'(bus.out_valid), 128'(0));
    check("t2_idle_busy", 128'(bus.busy), 128'(0));

    // 3: in_valid held across two blocks, no overlap
    bus.in_valid  = 1'b1;
    bus.cipher_in = CT1;
    @(negedge clk);
    check("t3_first_accept", 128'(bus.in_ready), 128'(0));
    wait_valid(n);
    check("t3_latency_a", 128'(n), 128'(10));
    check("t3_plain_a", bus.plain_out, PT1);
    repeat (2) begin
      @(negedge clk);
      check("t3_no_early_accept", 128'(bus.in_ready), 128'(0));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("t3_ready_after_pop", 128'(bus.in_ready), 128'(1));
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("t3_second_accept", 128'(bus.busy), 128'(1));
    wait_valid(n);
    check("t3_latency_b", 128'(n), 128'(10));
    check("t3_plain_b", bus.plain_out, PT1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // 4: reset in the middle of a block
    bus.in_valid  = 1'b1;
    bus.cipher_in = CT1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t4_rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("t4_rst_plain_out", bus.plain_out, 128'(0));
    check("t4_rst_in_ready", 128'(bus.in_ready), 128'(0));
    check("t4_rst_busy", 128'(bus.busy), 128'(1));
    rst = 1'b0;
    wait_ready(n);
    check("t4_keyexp_clocks", 128'(n), 128'(11));
    bus.in_valid  = 1'b1;
    bus.cipher_in = CT1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_valid(n);
    check("t4_latency", 128'(n), 128'(10));
    check("t4_plain", bus.plain_out, PT1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // 5: in_valid pulses during KEYEXP and ROUND are ignored
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.cipher_in = '0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("t5_keyexp_no_ready", 128'(bus.in_ready), 128'(0));
    // three edges already elapsed, in_ready follows the 11th
    wait_ready(n);
    check("t5_keyexp_remaining", 128'(n), 128'(8));
    @(negedge clk);
    check("t5_keyexp_pulse_dropped", 128'(bus.busy), 128'(0));
    bus.in_valid  = 1'b1;
    bus.cipher_in = CT1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.cipher_in = '0;
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    check("t5_round_no_valid", 128'(bus.out_valid), 128'(0));
    // four round edges consumed, six remain
    wait_valid(n);
    check("t5_latency_rest", 128'(n), 128'(6));
    check("t5_plain", bus.plain_out, PT1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("t5_round_pulse_dropped", 128'(bus.busy), 128'(0));

`ifdef AES_DEC_KEY_LOAD_EN
    // 6: key reload wins over a pending block, then FIPS-197 appendix B block
    bus.in_valid  = 1'b1;
    bus.cipher_in = CT2;
    bus.key_load  = 1'b1;
    bus.key_in    = KEY2;
    #1;
    check("t6_key_load_blocks_ready", 128'(bus.in_ready), 128'(0));
    @(negedge clk);
    bus.key_load = 1'b0;
    bus.in_valid = 1'b0;
    check("t6_keyexp_busy", 128'(bus.busy), 128'(1));
    wait_ready(n);
    check("t6_keyexp_clocks", 128'(n), 128'(11));
    bus.in_valid  = 1'b1;
    bus.cipher_in = CT2;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_valid(n);
    check("t6_latency", 128'(n), 128'(10));
    check("t6_plain", bus.plain_out, PT2);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
